// File: rtl/fetch_queue_unit_if.sv
// Fetch front-end bundle: instruction-memory request,
// redirect input and decode-side pop handshake.
interface fetch_queue_unit_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INST_WIDTH  = 32,
  parameter int QUEUE_DEPTH = 4
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_read;
  logic                  imem_ready;
  logic [INST_WIDTH-1:0] imem_read_data;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic                  id_ready;
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_pc;
  logic [INST_WIDTH-1:0] if_inst;

  logic                  fetch_misaligned;
  logic [ADDR_WIDTH-1:0] fault_pc;
  logic [CW-1:0]         queue_count;

  modport master (
    output imem_addr,
    output imem_read,
    input  imem_ready,
    input  imem_read_data,
    input  redirect_valid,
    input  redirect_pc,
    input  id_ready,
    output if_valid,
    output if_pc,
    output if_inst,
    output fetch_misaligned,
    output fault_pc,
    output queue_count
  );

  modport slave (
    input  imem_addr,
    input  imem_read,
    output imem_ready,
    output imem_read_data,
    output redirect_valid,
    output redirect_pc,
    output id_ready,
    input  if_valid,
    input  if_pc,
    input  if_inst,
    input  fetch_misaligned,
    input  fault_pc,
    input  queue_count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch front end: PC generator, imem request
// and a prefetch FIFO of {pc, inst} pairs popped by decode.
module fetch_queue_unit #(
  parameter int                  ADDR_WIDTH  = 32,
  parameter int                  INST_WIDTH  = 32,
  parameter int                  QUEUE_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = '0
) (
  input logic                 clk,
  input logic                 reset,
  fetch_queue_unit_if.master  bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  read_q;
  logic                  mis_q;
  logic [ADDR_WIDTH-1:0] fpc_q;

  logic [PW-1:0]         rd_q, rd_d;
  logic [PW-1:0]         wr_q, wr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0] pc_mem_q   [QUEUE_DEPTH];
  logic [INST_WIDTH-1:0] inst_mem_q [QUEUE_DEPTH];

  logic redir;
  logic aligned;
  logic push;
  logic pop;

  // A redirect voids any same-cycle push or pop; IDLE ignores it.
  assign redir   = bus.redirect_valid && (state_q != IDLE);
  assign aligned = (bus.redirect_pc[1:0] == 2'b00);
  assign push    = read_q && bus.imem_ready && !redir;
  assign pop     = (cnt_q != '0) && bus.id_ready && !redir;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (redir) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      unique case (1'b1)
        push && !pop: cnt_d = cnt_q + CW'(1);
        pop && !push: cnt_d = cnt_q - CW'(1);
        default:      cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      if (push) begin
        pc_mem_q[wr_q]   <= pc_q;
        inst_mem_q[wr_q] <= bus.imem_read_data;
      end
    end
  end

  // The request is registered from next-cycle occupancy so it
  // stays stable while imem_ready is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      read_q  <= 1'b0;
      mis_q   <= 1'b0;
      fpc_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_q <= FETCH;
          read_q  <= 1'b1;
        end
        FETCH, FAULT: begin
          if (bus.redirect_valid) begin
            if (aligned) begin
              state_q <= FETCH;
              pc_q    <= bus.redirect_pc;
              mis_q   <= 1'b0;
              read_q  <= 1'b1;
            end else begin
              state_q <= FAULT;
              mis_q   <= 1'b1;
              fpc_q   <= bus.redirect_pc;
              read_q  <= 1'b0;
            end
          end else if (state_q == FETCH) begin
            if (push) pc_q <= pc_q + ADDR_WIDTH'(4);
            read_q <= (cnt_d < FULL);
          end else begin
            read_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr        = pc_q;
  assign bus.imem_read        = read_q;
  assign bus.if_valid         = (cnt_q != '0);
  assign bus.if_pc            = pc_mem_q[rd_q];
  assign bus.if_inst          = inst_mem_q[rd_q];
  assign bus.fetch_misaligned = mis_q;
  assign bus.fault_pc         = fpc_q;
  assign bus.queue_count      = cnt_q;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomized scoreboard bench for fetch_queue_unit against
// a transaction-level queue model.
module tb_fetch_queue_unit;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  localparam int S_IDLE  = 0;
  localparam int S_FETCH = 1;
  localparam int S_FAULT = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  bit   run = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  int          mstate;
  logic [31:0] mpc;
  bit          mmis;
  logic [31:0] mfault;
  entry_t      exp_q[$];

  fetch_queue_unit_if #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .QUEUE_DEPTH(DEPTH)
  ) bus ();

  fetch_queue_unit #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW),
    .QUEUE_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mstate = S_IDLE;
    mpc    = RPC;
    mmis   = 1'b0;
    mfault = '0;
    exp_q.delete();
  endtask

  function automatic bit exp_read();
    return (mstate == S_FETCH) && (exp_q.size() < DEPTH);
  endfunction

  task automatic model_step();
    bit rd;
    rd = exp_read();
    if (mstate == S_IDLE) begin
      mstate = S_FETCH;
    end else if (bus.redirect_valid) begin
      exp_q.delete();
      if (bus.redirect_pc % 4 == 0) begin
        mstate = S_FETCH;
        mpc    = bus.redirect_pc;
        mmis   = 1'b0;
      end else begin
        mstate = S_FAULT;
        mmis   = 1'b1;
        mfault = bus.redirect_pc;
      end
    end else if (mstate == S_FETCH) begin
      if (exp_q.size() != 0 && bus.id_ready)
        void'(exp_q.pop_front());
      if (rd && bus.imem_ready) begin
        exp_q.push_back('{mpc, bus.imem_read_data});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic check_outputs();
    chk("imem_read", 64'(bus.imem_read), 64'(exp_read()));
    chk("imem_addr", 64'(bus.imem_addr), 64'(mpc));
    chk("queue_count", 64'(bus.queue_count),
        64'(exp_q.size()));
    chk("if_valid", 64'(bus.if_valid),
        64'(exp_q.size() != 0));
    chk("misaligned", 64'(bus.fetch_misaligned), 64'(mmis));
    if (mmis) chk("fault_pc", 64'(bus.fault_pc), 64'(mfault));
  endtask

  task automatic check_reset();
    chk("rst_imem_read", 64'(bus.imem_read), 64'(0));
    chk("rst_imem_addr", 64'(bus.imem_addr), 64'(RPC));
    chk("rst_if_valid", 64'(bus.if_valid), 64'(0));
    chk("rst_if_pc", 64'(bus.if_pc), 64'(0));
    chk("rst_if_inst", 64'(bus.if_inst), 64'(0));
    chk("rst_misaligned", 64'(bus.fetch_misaligned), 64'(0));
    chk("rst_fault_pc", 64'(bus.fault_pc), 64'(0));
    chk("rst_queue_count", 64'(bus.queue_count), 64'(0));
  endtask

  task automatic drive_idle();
    bus.imem_ready     = 1'b0;
    bus.imem_read_data = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;
  endtask

  task automatic drive_random(int cyc);
    logic [31:0] r;
    int          sel;
    bit          fill;
    fill = (cyc % 200) < 70;
    bus.imem_ready     = ($urandom_range(0, 3) != 0);
    bus.imem_read_data = $urandom;
    bus.id_ready       = fill ? ($urandom_range(0, 7) == 0)
                              : ($urandom_range(0, 4) != 0);
    bus.redirect_valid = ($urandom_range(0, 24) == 0);
    sel = $urandom_range(0, 9);
    r   = $urandom;
    unique case (1'b1)
      sel <= 5: r = r & 32'hFFFF_FFFC;
      sel == 6: r = 32'hFFFF_FFF8;
      sel == 9: r = 32'h0000_0100;
      default:  r = (r & 32'hFFFF_FFFC) |
                    32'($urandom_range(1, 3));
    endcase
    bus.redirect_pc = r;
  endtask

  // Monitor: whenever the head is presented, it must match the
  // oldest outstanding expected entry.
  always @(negedge clk) begin
    if (run && !reset && bus.if_valid && exp_q.size() != 0) begin
      chk("if_pc", 64'(bus.if_pc), 64'(exp_q[0].pc));
      chk("if_inst", 64'(bus.if_inst), 64'(exp_q[0].inst));
    end
  end

  initial begin
    bit did_rst;
    did_rst = 1'b0;
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset();
    reset = 1'b0;
    run   = 1'b1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      check_outputs();
      drive_random(cyc);
      if (cyc >= 2000 && !did_rst && exp_q.size() == 2 &&
          exp_read()) begin
        did_rst = 1'b1;
        bus.imem_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset();
        model_reset();
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
      end else begin
        @(posedge clk);
        model_step();
        @(negedge clk);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end for the pipelined CPU core. It replaces the fixed single-register IF stage with a PC generator, an instruction-memory request handshake and a QUEUE_DEPTH-entry prefetch FIFO of {pc, inst} pairs. Decode pops entries with a valid/ready handshake. Branch and jump redirects flush the queue and restart fetch, and a misaligned redirect target is flagged as a fault.

Parameters:
ADDR_WIDTH, 32, PC and instruction-memory address width
INST_WIDTH, 32, instruction word width
QUEUE_DEPTH, 4, prefetch FIFO entries; must be a power of two and at least 2
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous reset, active-high
imem_addr  output  ADDR_WIDTH  fetch address (current fetch PC)
imem_read  output  1  fetch request
imem_ready  input  1  request accepted; imem_read_data valid this cycle
imem_read_data  input  INST_WIDTH  fetched instruction
redirect_valid  input  1  branch/jump/jalr taken this cycle
redirect_pc  input  ADDR_WIDTH  redirect target
id_ready  input  1  decode can accept an instruction
if_valid  output  1  head entry valid
if_pc  output  ADDR_WIDTH  head entry PC
if_inst  output  INST_WIDTH  head entry instruction
fetch_misaligned  output  1  redirect target had [1:0] != 0
fault_pc  output  ADDR_WIDTH  offending target
queue_count  output  $clog2(QUEUE_DEPTH+1)  current occupancy

Behaviour:
- Reset values: fetch PC = RESET_PC; queue empty; state = IDLE; imem_read, if_valid and fetch_misaligned = 0; if_pc, if_inst, fault_pc and queue_count = 0. Asserting reset mid-transfer discards all state immediately.
- States: IDLE, FETCH, FAULT.
- IDLE: single cycle after reset deassertion, then FETCH.
- FETCH: imem_read = (queue_count < QUEUE_DEPTH). imem_addr = fetch PC in every state.
- Transfer occurs when imem_read && imem_ready: push {fetch PC, imem_read_data}, then fetch PC += 4, wrapping modulo 2^ADDR_WIDTH.
- While imem_ready is low: hold imem_addr and imem_read stable. No push occurs.
- Pop occurs when if_valid && id_ready. if_valid = (queue_count != 0). if_pc and if_inst are the head entry, driven from registers.
- Latency: there is no bypass. An instruction is visible on if_* exactly 1 cycle after its transfer cycle.
- Push and pop in the same cycle: queue_count is unchanged and order is preserved.
- Full (count == QUEUE_DEPTH): imem_read = 0. A pop that cycle frees a slot, and the request reasserts the next cycle.
- Empty: if_valid = 0, and id_ready is ignored.
- Pointers are log2(QUEUE_DEPTH) bits and wrap naturally.
- Redirect (redirect_valid=1) has highest priority over every other event in the same cycle:
  - The queue is flushed (count → 0 next cycle).
  - Any same-cycle transfer is discarded and any same-cycle pop is void.
  - If redirect_pc[1:0] == 0: fetch PC <= redirect_pc and state → FETCH.
  - Otherwise: state → FAULT, fetch_misaligned <= 1, fault_pc <= redirect_pc.
- FAULT: imem_read = 0 and the queue stays empty. fetch_misaligned holds until the next redirect_valid.
  - A next redirect that is aligned clears the fault and resumes FETCH.
  - A next redirect that is misaligned updates fault_pc and stays in FAULT.
- During IDLE, redirect_valid is ignored.
- imem_read is never asserted in IDLE or FAULT.

Test Plan:
- Reset then imem_ready=1, id_ready=1 → imem_addr 0x0,0x4,0x8,… on consecutive cycles. if_pc follows 1 cycle behind each transfer, and queue_count stays at 1.
- id_ready=0 with QUEUE_DEPTH=4 → 4 transfers (pc 0x0–0xC), then imem_read=0 and queue_count=4. Raising id_ready for 1 cycle pops 0x0, and the fetch of 0x10 issues the next cycle.
- imem_ready low for 3 cycles at pc 0x8 → imem_addr holds at 0x8, no push occurs, and if_* data is unchanged.
- redirect_valid with redirect_pc=0x100 in the same cycle as a transfer and a pop, with queue_count=3 → next cycle queue_count=0 and imem_addr=0x100. The first if_pc after the redirect is 0x100.
- redirect_pc=0x102 → fetch_misaligned=1, fault_pc=0x102, imem_read=0 until a later redirect to 0x200 clears the fault and fetch of 0x200 issues.
- Assert reset while queue_count=2 and a transfer is pending → all outputs return to reset values in the same cycle. The first fetch after release is at RESET_PC following the IDLE cycle.
